// File: rtl/counter_updown_load_mod_if.sv
// Control and status bundle for counter_updown_load_mod.
// The master drives the counter controls; the slave (the counter) returns
// its registered count and status flags.
interface counter_updown_load_mod_if #(
    parameter int WIDTH = 4
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] data;
    logic             enable;
    logic             up_down;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             overflow;

    modport master (
        output clear, load, data, enable, up_down,
        input  count, tc, wrap, overflow
    );

    modport slave (
        input  clear, load, data, enable, up_down,
        output count, tc, wrap, overflow
    );
endinterface

// File: rtl/counter_updown_load_mod.sv
// Parametrised up/down counter with parallel load, programmable modulus,
// wrap-or-saturate boundary behaviour, terminal count, a one-cycle wrap pulse
// and a sticky overflow flag.
module counter_updown_load_mod #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input  logic                         clock,
    input  logic                         reset,
    counter_updown_load_mod_if.slave     bus
);
    // Largest legal count; with MODULUS = 2^WIDTH this is all ones.
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam bit SAT = (SATURATE != 0);

    logic [WIDTH-1:0] count_q;
    logic             wrap_q;
    logic             overflow_q;

    logic [WIDTH-1:0] load_value;
    logic             at_max;
    logic             at_zero;

    // Out-of-range load values are clamped so count never exceeds MAX.
    assign load_value = (bus.data > MAX) ? MAX : bus.data;
    assign at_max     = (count_q == MAX);
    assign at_zero    = (count_q == ZERO);

    // Terminal count tracks direction combinationally, regardless of enable.
    assign bus.tc       = (bus.up_down & at_max) | (~bus.up_down & at_zero);
    assign bus.count    = count_q;
    assign bus.wrap     = wrap_q;
    assign bus.overflow = overflow_q;

    // Counter state: priority clear > load > enable > hold; wrap is a one-cycle pulse.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else if (bus.clear) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else if (bus.load) begin
            count_q    <= load_value;
            wrap_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else if (bus.enable) begin
            if (bus.up_down) begin
                if (!at_max) begin
                    count_q <= count_q + 1'b1;
                    wrap_q  <= 1'b0;
                end else begin
                    count_q    <= SAT ? MAX : ZERO;
                    wrap_q     <= !SAT;
                    overflow_q <= 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    count_q <= count_q - 1'b1;
                    wrap_q  <= 1'b0;
                end else begin
                    count_q    <= SAT ? ZERO : MAX;
                    wrap_q     <= !SAT;
                    overflow_q <= 1'b1;
                end
            end
        end else begin
            wrap_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_counter_updown_load_mod.sv
// Directed bench for counter_updown_load_mod: a wrapping modulo-10 counter,
// a saturating modulo-10 counter and a full-binary modulo-16 counter share
// one clock and reset, each driven through its own interface.
module tb_counter_updown_load_mod;
    logic clock;
    logic reset;

    int n_compared;
    int n_mismatched;

    counter_updown_load_mod_if #(.WIDTH(4)) if_w ();
    counter_updown_load_mod_if #(.WIDTH(4)) if_s ();
    counter_updown_load_mod_if #(.WIDTH(4)) if_b ();

    counter_updown_load_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_w (
        .clock (clock),
        .reset (reset),
        .bus   (if_w.slave)
    );

    counter_updown_load_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_s (
        .clock (clock),
        .reset (reset),
        .bus   (if_s.slave)
    );

    counter_updown_load_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (if_b.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;

        if_w.clear = 0; if_w.load = 0; if_w.data = 0; if_w.enable = 0; if_w.up_down = 1;
        if_s.clear = 0; if_s.load = 0; if_s.data = 0; if_s.enable = 0; if_s.up_down = 1;
        if_b.clear = 0; if_b.load = 0; if_b.data = 0; if_b.enable = 0; if_b.up_down = 1;
        reset = 1;
        #2;
        check("reset_count", if_w.count, 0);
        check("reset_wrap", if_w.wrap, 0);
        check("reset_ovf", if_w.overflow, 0);
        tick();
        reset = 0;

        // Count to 7, then reset asynchronously mid-cycle.
        if_w.enable = 1; if_w.up_down = 1;
        for (int i = 0; i < 7; i++) tick();
        check("pre_reset_count7", if_w.count, 7);
        #2 reset = 1;
        #1;
        check("async_reset_count", if_w.count, 0);
        check("async_reset_wrap", if_w.wrap, 0);
        check("async_reset_ovf", if_w.overflow, 0);
        #1 reset = 0;
        for (int i = 0; i < 3; i++) tick();
        check("after_reset_up3", if_w.count, 3);

        // Up wrap: load 8, step to 9 then 0.
        if_w.enable = 0; if_w.load = 1; if_w.data = 8;
        tick();
        if_w.load = 0;
        check("load8", if_w.count, 8);
        check("tc_at_8", if_w.tc, 0);
        if_w.enable = 1;
        tick();
        check("up_to_9", if_w.count, 9);
        check("up_to_9_wrap", if_w.wrap, 0);
        check("tc_at_9_up", if_w.tc, 1);
        tick();
        check("up_wrap_count", if_w.count, 0);
        check("up_wrap_pulse", if_w.wrap, 1);
        check("up_wrap_ovf", if_w.overflow, 1);
        if_w.enable = 0;
        tick();
        check("idle_wrap_drops", if_w.wrap, 0);
        check("idle_ovf_sticky", if_w.overflow, 1);
        check("idle_count_holds", if_w.count, 0);

        // Async reset clears a set overflow flag without a clock edge.
        #2 reset = 1;
        #1;
        check("async_reset_clears_ovf", if_w.overflow, 0);
        #1 reset = 0;
        tick();

        // Down wrap and clamp.
        if_w.load = 1; if_w.data = 15;
        tick();
        check("load15_clamped", if_w.count, 9);
        if_w.data = 1; if_w.up_down = 0;
        tick();
        if_w.load = 0;
        check("load1", if_w.count, 1);
        if_w.enable = 1;
        tick();
        check("down_to_0", if_w.count, 0);
        check("down_to_0_wrap", if_w.wrap, 0);
        check("tc_at_0_down", if_w.tc, 1);
        tick();
        check("down_wrap_count", if_w.count, 9);
        check("down_wrap_pulse", if_w.wrap, 1);
        check("down_wrap_ovf", if_w.overflow, 1);
        if_w.enable = 0;
        tick();
        check("down_single_pulse", if_w.wrap, 0);
        check("down_count_holds", if_w.count, 9);

        // Priority: load beats enable, clear beats load.
        if_w.load = 1; if_w.data = 4;
        tick();
        check("load4", if_w.count, 4);
        check("load_clears_ovf", if_w.overflow, 0);
        if_w.data = 2; if_w.enable = 1; if_w.up_down = 1;
        tick();
        check("load_beats_enable", if_w.count, 2);
        if_w.clear = 1; if_w.data = 5;
        tick();
        if_w.clear = 0; if_w.load = 0; if_w.enable = 0;
        check("clear_beats_load", if_w.count, 0);

        // tc follows up_down combinationally at count 9.
        if_w.load = 1; if_w.data = 9;
        tick();
        if_w.load = 0;
        if_w.up_down = 1;
        #1;
        check("tc_toggle_up", if_w.tc, 1);
        if_w.up_down = 0;
        #1;
        check("tc_toggle_down", if_w.tc, 0);
        if_w.up_down = 1;
        #1;
        check("tc_toggle_up_again", if_w.tc, 1);

        // Clear resets a set overflow flag.
        if_w.enable = 1;
        tick();
        check("wrap_before_clear_ovf", if_w.overflow, 1);
        if_w.enable = 0; if_w.clear = 1;
        tick();
        if_w.clear = 0;
        check("clear_clears_ovf", if_w.overflow, 0);
        check("clear_count", if_w.count, 0);

        // Saturating counter.
        if_s.load = 1; if_s.data = 9;
        tick();
        if_s.load = 0;
        check("sat_load9", if_s.count, 9);
        if_s.enable = 1; if_s.up_down = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sat_up_count", if_s.count, 9);
            check("sat_up_wrap", if_s.wrap, 0);
            check("sat_up_ovf", if_s.overflow, 1);
        end
        if_s.enable = 0; if_s.load = 1; if_s.data = 0;
        tick();
        if_s.load = 0;
        check("sat_load0_ovf", if_s.overflow, 0);
        if_s.enable = 1; if_s.up_down = 0;
        tick();
        check("sat_down_count", if_s.count, 0);
        check("sat_down_wrap", if_s.wrap, 0);
        check("sat_down_ovf", if_s.overflow, 1);
        if_s.enable = 0; if_s.load = 1; if_s.data = 5;
        tick();
        if_s.load = 0;
        check("sat_load5_count", if_s.count, 5);
        check("sat_load5_ovf", if_s.overflow, 0);

        // Full binary modulus: 16 up steps from 0, one wrap at 15 -> 0.
        if_b.clear = 1;
        tick();
        if_b.clear = 0;
        check("bin_start", if_b.count, 0);
        if_b.enable = 1; if_b.up_down = 1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("bin_count", if_b.count, (i + 1) % 16);
            check("bin_wrap", if_b.wrap, (i == 15) ? 1 : 0);
        end
        if_b.enable = 0;
        tick();
        check("bin_wrap_drops", if_b.wrap, 0);
        check("bin_ovf", if_b.overflow, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/counter_updown_load_mod.md
# counter_updown_load_mod

Parametrised synchronous up/down counter with parallel load, programmable modulus, selectable wrap or saturate behaviour, terminal-count and wrap-pulse outputs, and a sticky overflow flag. It generalises the team's 4-bit loadable up counter. It is the general-purpose counting primitive for timers, dividers and sequence indexing in the lab designs.

## Interface
- WIDTH, 4: counter width in bits; must be ≥ 2.
- MODULUS, 16: count range is 0..MODULUS-1; 2 ≤ MODULUS ≤ 2^WIDTH.
- SATURATE, 0: 0 = wrap at boundaries; 1 = hold at boundaries.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear to 0.
- load  in  1  synchronous parallel load of data.
- data  in  WIDTH  load value.
- enable  in  1  count enable.
- up_down  in  1  count direction: 1 = up, 0 = down.
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal count, combinational from count and up_down.
- wrap  out  1  one-cycle registered pulse marking a boundary crossing.
- overflow  out  1  sticky, registered.

## Operation
- MAX = MODULUS-1.
- Priority per rising edge: reset (async) > clear > load > enable > hold.
- **reset** asserted: immediately, without waiting for a clock edge, count=0, wrap=0, overflow=0.
- **clear**: count←0, wrap←0, overflow←0.
- **load**:
  - count←data if data ≤ MAX; otherwise count←MAX (clamped).
  - wrap←0, overflow←0.
  - enable and up_down are ignored that cycle.
- **enable, up_down=1**:
  - count<MAX: count←count+1, wrap←0.
  - count=MAX, SATURATE=0: count←0, wrap←1, overflow←1.
  - count=MAX, SATURATE=1: count holds MAX, wrap←0, overflow←1.
- **enable, up_down=0**:
  - count>0: count←count-1, wrap←0.
  - count=0, SATURATE=0: count←MAX, wrap←1, overflow←1.
  - count=0, SATURATE=1: count holds 0, wrap←0, overflow←1.
- **Idle** (no clear, load or enable): count holds, wrap←0, overflow holds.
- tc = (up_down & count==MAX) | (~up_down & count==0).
  - Independent of enable.
  - Changes combinationally when up_down toggles.
- Arithmetic:
  - Modulo MODULUS, not 2^WIDTH.
  - count never holds a value > MAX.
  - Comparisons are WIDTH bits wide, unsigned.
- MODULUS = 2^WIDTH is legal; MAX is then all ones and wrap behaviour matches natural binary roll-over.
- Direction changes take effect on the next enabled edge. No dead cycle is inserted.

## Timing
- Latency:
  - count reflects load, clear or a step one clock after the edge that samples it.
  - Inputs are sampled on the rising edge.
- Async reset:
  - Outputs reach their reset values within the reset assertion, without a clock edge.
  - Deassertion is synchronised externally.
  - The first count/load is evaluated on the first rising edge after deassertion.
- Reset mid-count: state is lost; count=0 on assertion; no wrap pulse is generated.
- wrap:
  - High for exactly one cycle per boundary crossing.
  - Continuous enabled counting with MODULUS=2 gives a wrap on every second cycle.
- overflow: remains 1 until reset, clear or load.
- Simultaneous events:
  - load + enable: load wins.
  - clear + load: clear wins.
  - reset overrides all.

## Test plan
All scenarios use WIDTH=4, MODULUS=10 unless stated.

- **Reset:**
  - Assert reset mid-cycle while count=7 → count=0, wrap=0, overflow=0 before the next edge.
  - Deassert, enable up for 3 edges → count=3.
- **Up wrap (SATURATE=0):**
  - Load 8, enable up for 2 edges → count 9 then 0.
  - wrap=1 exactly in the cycle after 9→0.
  - overflow=1 and stays 1.
  - tc=1 while count=9.
- **Down wrap and clamp:**
  - Load 15 → count=9 (clamped).
  - Load 1, enable down for 2 edges → 0 then 9, with a single wrap pulse.
  - tc=1 while count=0 with up_down=0.
- **Saturate (SATURATE=1):**
  - Load 9, enable up for 3 edges → count stays 9, wrap stays 0, overflow=1.
  - Down from 0 → count stays 0.
  - A subsequent load 5 clears overflow.
- **Priority:**
  - count=4, assert load=1 (data=2), enable=1, up_down=1 → count=2.
  - clear=1 with load=1 → count=0.
  - Toggle up_down at count=9 → tc follows combinationally: 1 for up, 0 for down.
- **Full binary (WIDTH=4, MODULUS=16):**
  - Enable up for 16 edges from 0 → count returns to 0, with exactly one wrap at the 15→0 transition.
